// File: rtl/select_encode_regfile.sv
// Register-select encoder and 16 x 32 general-purpose register file for the bus datapath.
// Optional macro REG_PRELOAD_EN: reset loads reg[PRELOAD_IDX] with PRELOAD_VAL.
module select_encode_regfile #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_REGS    = 16,
    parameter int unsigned       PRELOAD_IDX = 3,
    parameter logic [DATA_W-1:0] PRELOAD_VAL = 32'hB6
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic [31:0]                  ir,
    input  logic                         gra,
    input  logic                         grb,
    input  logic                         grc,
    input  logic                         r_in,
    input  logic                         r_out,
    input  logic                         ba_out,
    input  logic [DATA_W-1:0]            bus_mux_out,
    output logic [NUM_REGS-1:0]          r_out_onehot,
    output logic [NUM_REGS*DATA_W-1:0]   bus_mux_in_r,
    output logic                         wr_strobe,
    output logic [3:0]                   wr_idx,
    output logic [15:0]                  wr_count
);

    localparam int unsigned SEL_W = 4;

    logic [SEL_W-1:0]    ra, rb, rc;
    logic [SEL_W-1:0]    sel;
    logic                sel_valid;
    logic [NUM_REGS-1:0] sel_onehot;
    logic                write_en;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // Only the three register fields of the IR are consumed here.
    logic unused_ir;
    assign unused_ir = ^{ir[31:27], ir[14:0]};

    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];

    // Field select with priority gra > grb > grc.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        if (gra) begin
            sel       = ra;
            sel_valid = 1'b1;
        end else if (grb) begin
            sel       = rb;
            sel_valid = 1'b1;
        end else if (grc) begin
            sel       = rc;
            sel_valid = 1'b1;
        end
    end

    assign sel_onehot   = sel_valid ? (NUM_REGS'(1) << sel) : '0;
    assign r_out_onehot = (r_out | ba_out) ? sel_onehot : '0;
    assign write_en     = r_in & sel_valid;

    // Register array; reset wins over a simultaneous write.
    always_ff @(posedge clock) begin
        if (!clear) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
`ifdef REG_PRELOAD_EN
                regs[i] <= (i == PRELOAD_IDX) ? PRELOAD_VAL : '0;
`else
                regs[i] <= '0;
`endif
            end
        end else if (write_en) begin
            regs[sel] <= bus_mux_out;
        end
    end

    // Write status: one-cycle strobe, last index, wrapping write count.
    always_ff @(posedge clock) begin
        if (!clear) begin
            wr_strobe <= 1'b0;
            wr_idx    <= '0;
            wr_count  <= '0;
        end else if (write_en) begin
            wr_strobe <= 1'b1;
            wr_idx    <= sel;
            wr_count  <= wr_count + 16'd1;
        end else begin
            wr_strobe <= 1'b0;
        end
    end

    // R0 reads as zero when used as a base address.
    assign bus_mux_in_r[DATA_W-1:0] = (ba_out && sel_valid && (sel == '0)) ? '0 : regs[0];

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_slice
        assign bus_mux_in_r[DATA_W*k +: DATA_W] = regs[k];
    end

endmodule
